// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character player: FSM states,
// ROM entry layout, unit multipliers and the phase-length helper.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_CHAR_GAP,
        ST_DONE
    } state_t;

    localparam logic [5:0] CODE_MAX = 6'd35;

    // pat is MSB-first and left-aligned: pat[4] is the first symbol, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } rom_entry_t;

    localparam logic [1:0] MULT_DOT   = 2'd1;
    localparam logic [1:0] MULT_DASH  = 2'd3;
    localparam logic [1:0] MULT_SPACE = 2'd1;
    localparam logic [1:0] MULT_GAP   = 2'd3;

    // Down-counter reload for an n-unit phase; the product is formed at 34 bits
    // and truncated, so out-of-range UNIT_CYCLES simply wraps.
    function automatic logic [31:0] phase_load(input logic [1:0] mult, input logic [31:0] unit);
        logic [33:0] prod;
        prod = {32'd0, mult} * {2'b00, unit} - 34'd1;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character table: 6-bit code -> {valid, len, pat} for A-Z, 0-9.
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0]  char_code,
    output logic        valid,
    output rom_entry_t  entry
);

    always_comb begin
        valid = (char_code <= CODE_MAX);
        entry = '0;
        case (char_code)
            6'd0:  entry = '{3'd2, 5'b01000}; // A .-
            6'd1:  entry = '{3'd4, 5'b10000}; // B -...
            6'd2:  entry = '{3'd4, 5'b10100}; // C -.-.
            6'd3:  entry = '{3'd3, 5'b10000}; // D -..
            6'd4:  entry = '{3'd1, 5'b00000}; // E .
            6'd5:  entry = '{3'd4, 5'b00100}; // F ..-.
            6'd6:  entry = '{3'd3, 5'b11000}; // G --.
            6'd7:  entry = '{3'd4, 5'b00000}; // H ....
            6'd8:  entry = '{3'd2, 5'b00000}; // I ..
            6'd9:  entry = '{3'd4, 5'b01110}; // J .---
            6'd10: entry = '{3'd3, 5'b10100}; // K -.-
            6'd11: entry = '{3'd4, 5'b01000}; // L .-..
            6'd12: entry = '{3'd2, 5'b11000}; // M --
            6'd13: entry = '{3'd2, 5'b10000}; // N -.
            6'd14: entry = '{3'd3, 5'b11100}; // O ---
            6'd15: entry = '{3'd4, 5'b01100}; // P .--.
            6'd16: entry = '{3'd4, 5'b11010}; // Q --.-
            6'd17: entry = '{3'd3, 5'b01000}; // R .-.
            6'd18: entry = '{3'd3, 5'b00000}; // S ...
            6'd19: entry = '{3'd1, 5'b10000}; // T -
            6'd20: entry = '{3'd3, 5'b00100}; // U ..-
            6'd21: entry = '{3'd4, 5'b00010}; // V ...-
            6'd22: entry = '{3'd3, 5'b01100}; // W .--
            6'd23: entry = '{3'd4, 5'b10010}; // X -..-
            6'd24: entry = '{3'd4, 5'b10110}; // Y -.--
            6'd25: entry = '{3'd4, 5'b11000}; // Z --..
            6'd26: entry = '{3'd5, 5'b11111}; // 0
            6'd27: entry = '{3'd5, 5'b01111}; // 1
            6'd28: entry = '{3'd5, 5'b00111}; // 2
            6'd29: entry = '{3'd5, 5'b00011}; // 3
            6'd30: entry = '{3'd5, 5'b00001}; // 4
            6'd31: entry = '{3'd5, 5'b00000}; // 5
            6'd32: entry = '{3'd5, 5'b10000}; // 6
            6'd33: entry = '{3'd5, 5'b11000}; // 7
            6'd34: entry = '{3'd5, 5'b11100}; // 8
            6'd35: entry = '{3'd5, 5'b11110}; // 9
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/morse_char_player.sv
// Plays one Morse character with exact unit timing and drives the buzzer pair.
// Every output is a flop loaded from the next-state decode.
module morse_char_player
    import morse_pkg::*;
#(
    parameter logic [31:0] UNIT_CYCLES = 32'd6_000_000,
    parameter logic [31:0] TONE_HALF   = 32'd28409,
    parameter logic [31:0] IDLE_HALF   = 32'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  char_code,
    input  logic        abort,
    output logic        enable,
    output logic [31:0] freq,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  sym_idx
);

    logic       rom_valid;
    rom_entry_t rom_entry;

    morse_rom u_rom (
        .char_code (char_code),
        .valid     (rom_valid),
        .entry     (rom_entry)
    );

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  len_q, len_d;
    logic [4:0]  pat_q, pat_d;
    logic [2:0]  sym_idx_q, sym_idx_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] freq_q, freq_d;

    logic        phase_end;
    logic [2:0]  bit_sel;
    logic        next_dash;

    assign phase_end = (timer_q == 32'd0);
    // sym_idx has already advanced when SPACE ends, so this selects the upcoming symbol
    assign bit_sel   = 3'd4 - sym_idx_q;
    assign next_dash = pat_q[bit_sel];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        len_d     = len_q;
        pat_d     = pat_q;
        sym_idx_d = sym_idx_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (rom_valid) begin
                        len_d     = rom_entry.len;
                        pat_d     = rom_entry.pat;
                        sym_idx_d = 3'd0;
                        timer_d   = phase_load(rom_entry.pat[4] ? MULT_DASH : MULT_DOT, UNIT_CYCLES);
                        state_d   = ST_MARK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (!phase_end) begin
                    timer_d = timer_q - 32'd1;
                end else if (sym_idx_q == len_q - 3'd1) begin
                    timer_d = phase_load(MULT_GAP, UNIT_CYCLES);
                    state_d = ST_CHAR_GAP;
                end else begin
                    sym_idx_d = sym_idx_q + 3'd1;
                    timer_d   = phase_load(MULT_SPACE, UNIT_CYCLES);
                    state_d   = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (!phase_end) begin
                    timer_d = timer_q - 32'd1;
                end else begin
                    timer_d = phase_load(next_dash ? MULT_DASH : MULT_DOT, UNIT_CYCLES);
                    state_d = ST_MARK;
                end
            end
            ST_CHAR_GAP: begin
                if (!phase_end) begin
                    timer_d = timer_q - 32'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            timer_d = 32'd0;
        end

        if (state_d == ST_IDLE) begin
            sym_idx_d = 3'd0;
        end

        enable_d = (state_d == ST_MARK);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        freq_d   = enable_d ? TONE_HALF : IDLE_HALF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= 32'd0;
            len_q     <= 3'd0;
            pat_q     <= 5'd0;
            sym_idx_q <= 3'd0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            freq_q    <= IDLE_HALF;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            len_q     <= len_d;
            pat_q     <= pat_d;
            sym_idx_q <= sym_idx_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            freq_q    <= freq_d;
        end
    end

    assign enable  = enable_q;
    assign freq    = freq_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign sym_idx = sym_idx_q;

endmodule

// File: tb/tb_morse_char_player.sv
// Directed bench for morse_char_player with UNIT_CYCLES=4: traced characters
// checked against a hand-computed vector table, plus abort/reset/invalid sequences.
module tb_morse_char_player;

    localparam int TR = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  char_code = 6'd0;
    logic        abort = 1'b0;
    logic        enable;
    logic [31:0] freq;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  sym_idx;

    int checks = 0;
    int errors = 0;

    morse_char_player #(
        .UNIT_CYCLES (32'd4),
        .TONE_HALF   (32'd28409),
        .IDLE_HALF   (32'd100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .char_code (char_code),
        .abort     (abort),
        .enable    (enable),
        .freq      (freq),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sym_idx   (sym_idx)
    );

    always #5 clk = ~clk;

    logic        en_tr   [0:TR];
    logic        busy_tr [0:TR];
    logic        done_tr [0:TR];
    logic        err_tr  [0:TR];
    logic [2:0]  sym_tr  [0:TR];
    logic [31:0] freq_tr [0:TR];

    typedef struct {
        logic [5:0] code;
        int         inj;
        int         cyc;
        logic       en;
        logic       busy;
        logic       done;
        logic [2:0] sym;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // start at cycle 0, record outputs for cycles 0..TR; inj>0 pulses start with code 0 at that cycle
    task automatic play(input logic [5:0] code, input int inj);
        int n_done, n_err, n_freq;
        @(posedge clk); #1;
        start = 1'b1; char_code = code;
        for (int c = 0; c <= TR; c++) begin
            if (c > 0) begin
                start     = (c == inj);
                char_code = (c == inj) ? 6'd0 : code;
            end
            @(negedge clk);
            en_tr[c] = enable; busy_tr[c] = busy; done_tr[c] = done;
            err_tr[c] = err; sym_tr[c] = sym_idx; freq_tr[c] = freq;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_done = 0; n_err = 0; n_freq = 0;
        for (int c = 0; c <= TR; c++) begin
            if (done_tr[c]) n_done++;
            if (err_tr[c]) n_err++;
            if (freq_tr[c] !== (en_tr[c] ? 32'd28409 : 32'd100)) n_freq++;
        end
        chk($sformatf("done_once_code%0d", code), n_done, 1);
        chk($sformatf("no_err_code%0d", code), n_err, 0);
        chk($sformatf("freq_track_code%0d", code), n_freq, 0);
    endtask

    task automatic wait_done(input string name, input int bound);
        int seen;
        seen = 0;
        for (int c = 0; c < bound && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int cur_code, cur_inj;

        // code, inj, cycle, enable, busy, done, sym_idx
        vecs.push_back('{6'd4, 0, 0, 1'b0, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 0, 1, 1'b1, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 0, 4, 1'b1, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 0, 5, 1'b0, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 0, 16, 1'b0, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 0, 17, 1'b0, 1'b1, 1'b1, 3'd0});
        vecs.push_back('{6'd4, 0, 18, 1'b0, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 10, 1, 1'b1, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 10, 5, 1'b0, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 10, 11, 1'b0, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 10, 16, 1'b0, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd4, 10, 17, 1'b0, 1'b1, 1'b1, 3'd0});
        vecs.push_back('{6'd4, 10, 18, 1'b0, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{6'd0, 0, 4, 1'b1, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd0, 0, 5, 1'b0, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd0, 0, 8, 1'b0, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd0, 0, 9, 1'b1, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd0, 0, 20, 1'b1, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd0, 0, 21, 1'b0, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd0, 0, 32, 1'b0, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd0, 0, 33, 1'b0, 1'b1, 1'b1, 3'd1});
        vecs.push_back('{6'd0, 0, 34, 1'b0, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{6'd26, 0, 12, 1'b1, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{6'd26, 0, 13, 1'b0, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd26, 0, 17, 1'b1, 1'b1, 1'b0, 3'd1});
        vecs.push_back('{6'd26, 0, 64, 1'b0, 1'b1, 1'b0, 3'd4});
        vecs.push_back('{6'd26, 0, 65, 1'b1, 1'b1, 1'b0, 3'd4});
        vecs.push_back('{6'd26, 0, 76, 1'b1, 1'b1, 1'b0, 3'd4});
        vecs.push_back('{6'd26, 0, 77, 1'b0, 1'b1, 1'b0, 3'd4});
        vecs.push_back('{6'd26, 0, 88, 1'b0, 1'b1, 1'b0, 3'd4});
        vecs.push_back('{6'd26, 0, 89, 1'b0, 1'b1, 1'b1, 3'd4});
        vecs.push_back('{6'd26, 0, 90, 1'b0, 1'b0, 1'b0, 3'd0});

        // reset values
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_enable", enable, 0);
        chk("rst_freq", freq, 100);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sym", sym_idx, 0);

        cur_code = -1; cur_inj = -1;
        foreach (vecs[i]) begin
            if (int'(vecs[i].code) != cur_code || vecs[i].inj != cur_inj) begin
                cur_code = int'(vecs[i].code);
                cur_inj  = vecs[i].inj;
                play(vecs[i].code, vecs[i].inj);
            end
            chk($sformatf("c%0d_i%0d_cyc%0d_enable", cur_code, cur_inj, vecs[i].cyc), en_tr[vecs[i].cyc], vecs[i].en);
            chk($sformatf("c%0d_i%0d_cyc%0d_busy", cur_code, cur_inj, vecs[i].cyc), busy_tr[vecs[i].cyc], vecs[i].busy);
            chk($sformatf("c%0d_i%0d_cyc%0d_done", cur_code, cur_inj, vecs[i].cyc), done_tr[vecs[i].cyc], vecs[i].done);
            chk($sformatf("c%0d_i%0d_cyc%0d_sym", cur_code, cur_inj, vecs[i].cyc), sym_tr[vecs[i].cyc], vecs[i].sym);
        end

        // invalid code 40, then a valid start two cycles later
        @(posedge clk); #1;
        start = 1'b1; char_code = 6'd40;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("inv_err_c1", err, 1);
        chk("inv_busy_c1", busy, 0);
        chk("inv_enable_c1", enable, 0);
        @(posedge clk); #1;
        start = 1'b1; char_code = 6'd4;
        @(negedge clk);
        chk("inv_err_c2", err, 0);
        chk("inv_done_c2", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("inv_next_enable", enable, 1);
        chk("inv_next_busy", busy, 1);
        wait_done("inv_next_done", 40);

        // abort during the first dash of 'O'
        @(posedge clk); #1;
        start = 1'b1; char_code = 6'd14;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_c6_enable", enable, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_c7_enable", enable, 0);
        chk("abort_c7_busy", busy, 0);
        chk("abort_c7_sym", sym_idx, 0);
        chk("abort_c7_done", done, 0);
        @(posedge clk); #1;
        start = 1'b1; char_code = 6'd4;
        @(negedge clk);
        chk("abort_c8_done", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_restart_enable", enable, 1);
        chk("abort_restart_busy", busy, 1);
        wait_done("abort_restart_done", 40);

        // abort in IDLE wins over start
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; char_code = 6'd4;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_enable", enable, 0);
        chk("idle_abort_err", err, 0);

        // asynchronous reset during the 'E' mark
        @(posedge clk); #1;
        start = 1'b1; char_code = 6'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rstmid_c3_enable", enable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_enable", enable, 0);
        chk("rstmid_async_freq", freq, 100);
        chk("rstmid_async_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_after_busy", busy, 0);
        chk("rstmid_after_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
